decode_issue_stage: RTL and testbench
=====================================

Name: decode_issue_stage

Overview:
- Pipelined successor to the combinational RV32I control decoder.
- Decodes the instruction in ID and registers the full control bundle into the ID/EX pipeline register.
- Owns a per-register latency scoreboard. It stalls ID only when a source register is not yet forwardable. Loads and, optionally, M-extension ops have parameterised result latency.
- Sits between the IF/ID register and EX; forwarding muxes live in EX.

Parameters:
- XLEN, 32, data/instruction width (RV32 only; fixed 32 for now)
- EN_M, 0, 1 = decode RV32M (funct7=0000001) as valid; 0 = treat it as illegal
- LOAD_LAT, 1, EX-advance cycles after load issue before rd is forwardable (0 = no load scoreboarding)
- MD_LAT, 3, same for MUL/DIV results (used only when EN_M=1)
- ALU_OPW, 5, alu_op width

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_id_instr  in  32  instruction in ID
- i_id_vld  in  1  ID holds a real instruction
- o_id_rdy  out  1  ID instruction is accepted this cycle (combinational)
- i_ex_stall  in  1  downstream freeze; hold the ID/EX register
- i_flush  in  1  drop the current ID instruction (taken branch/jump in EX)
- o_ex_vld  out  1  register holds a real instruction
- o_ex_ctrl  out  struct  rd_wren, mem_wren, mem_rden, op_a_sel, op_b_sel, wb_sel[1:0], alu_op[ALU_OPW-1:0], funct3[2:0], lsu_size[1:0], l_unsigned, is_branch, br_un, is_jump, is_muldiv, insn_vld
- o_ex_rd, o_ex_rs1, o_ex_rs2  out  5 each  register indices
- o_ex_use_rs1, o_ex_use_rs2  out  1 each  source actually read
- o_ex_instr  out  32  instruction passthrough for immediate generation

Behaviour:
- Reset (async): o_ex_vld=0; o_ex_ctrl all fields 0; indices 0; o_ex_instr=32'h0000_0013 (NOP); all scoreboard counters 0.
- Decode (combinational, ID):
  - Opcode classes: RTYPE, ITYPE, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - alu_op encoding: ADD=0, SUB=1, SLT=2, SLTU=3, XOR=4, OR=5, AND=6, SLL=7, SRL=8, SRA=9, MUL..REMU=16..23 (funct3 order).
  - lsu_size: 0 byte, 1 half, 2 word.
  - Stores use the standard encoding: SB=0, SH=1, SW=2.
  - use_rs1 is 0 for LUI, AUIPC and JAL. use_rs2 is 1 only for RTYPE, STORE and BRANCH.
- Illegal encodings (unknown opcode, bad funct3, RTYPE funct7 not 0000000/0100000, M op with EN_M=0):
  - insn_vld=0 and rd_wren=mem_wren=mem_rden=is_branch=is_jump=0.
  - The instruction still issues; the trap is handled downstream.
- Hazard (combinational): hazard=1 iff (use_rs1 && rs1!=0 && cnt[rs1]!=0) || (use_rs2 && rs2!=0 && cnt[rs2]!=0).
- Handshake:
  - o_id_rdy = !i_ex_stall && !hazard.
  - capture = i_id_vld && o_id_rdy && !i_flush.
- Register update:
  - i_ex_stall=1: hold everything, including the counters.
  - Else, if capture: load the decoded bundle, o_ex_vld=1.
  - Else: load a bubble (o_ex_vld=0, ctrl all 0).
- Scoreboard (cnt[1..31], width $clog2(max(LOAD_LAT,MD_LAT)+1); cnt[0] fixed 0):
  - Every non-stalled cycle, each nonzero counter decrements by 1.
  - On capture, if rd!=0 and the instruction is a legal load: cnt[rd]=LOAD_LAT. If it is a legal muldiv: cnt[rd]=MD_LAT. This write overrides the decrement.
  - All other writers (ALU, JAL, LUI, ...) clear cnt[rd]=0, because their result is forwardable from EX.
- i_flush: the ID instruction is never captured, so it never touches the scoreboard. In-flight entries are untouched.
- Simultaneous i_flush and i_ex_stall: the stall wins; the register holds; the ID instruction is still dropped.
- Self-dependence (e.g. lw x5,0(x5)): hazard is checked against pre-update counters.
- Latency: 1 cycle from ID capture to o_ex_*.
- Reset mid-stall: everything clears; no pending entries survive.

Decomposition:
- Package decode_pkg:
  - opcode localparams
  - alu_op_e enum
  - lsu_size_e
  - ex_ctrl_t packed struct
  - NOP constant
- Sub-module scoreboard_cnt:
  - counters, decrement/set/clear logic
  - hazard output from rs1/rs2/use inputs
- The decode function lives in the package; the top holds the register and the handshake.

Test Plan:
- Reset mid-operation (i_reset pulsed while cnt[5]=1) -> o_ex_vld=0, o_ex_instr=0x00000013, next dependent on x5 issues with no stall.
- add x3,x1,x2 (0x002081B3), i_id_vld=1 -> next cycle o_ex_vld=1, alu_op=0, rd=3, rd_wren=1, use_rs1=use_rs2=1.
- lw x5,0(x1) (0x0000A283) then add x6,x5,x0 (0x00028333), LOAD_LAT=1 -> o_id_rdy=0 for 1 cycle, o_ex_vld sequence 1,0,1; lw x0 followed by a use of x0 -> no stall.
- EN_M=1, MD_LAT=3: mul x7,x1,x2 (0x022083B3) then sub x8,x7,x1 -> 3 bubbles, alu_op=16, is_muldiv=1; EN_M=0 -> insn_vld=0, rd_wren=0, no stall on the following instruction.
- Pending load with i_ex_stall=1 for 2 cycles -> outputs and cnt frozen; after release, exactly LOAD_LAT bubbles remain.
- i_flush=1 with lw x9 in ID -> bubble issued; next add using x9 issues immediately (no scoreboard entry).

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared types and the RV32I(+M) decode function for the decode/issue stage.
//   - opcode localparams, alu_op_e, lsu_size_e, wb_sel encodings
//   - ex_ctrl_t: control bundle carried in the ID/EX register
//   - dec_t: ex_ctrl_t plus source-usage flags (used for hazard checking and forwarding)
//   - decode(): pure combinational decode of funct7/funct3/opcode
package decode_pkg;

  localparam int ALU_OPW = 5;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Writeback source: ALU result, load data, PC+4 (links), raw U-immediate (LUI)
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  typedef enum logic [ALU_OPW-1:0] {
    ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_SLT  = 5'd2,  ALU_SLTU = 5'd3,
    ALU_XOR = 5'd4,  ALU_OR  = 5'd5,  ALU_AND  = 5'd6,  ALU_SLL  = 5'd7,
    ALU_SRL = 5'd8,  ALU_SRA = 5'd9,
    ALU_MUL = 5'd16, ALU_MULH = 5'd17, ALU_MULHSU = 5'd18, ALU_MULHU = 5'd19,
    ALU_DIV = 5'd20, ALU_DIVU = 5'd21, ALU_REM    = 5'd22, ALU_REMU  = 5'd23
  } alu_op_e;

  typedef enum logic [1:0] {LSU_B = 2'd0, LSU_H = 2'd1, LSU_W = 2'd2} lsu_size_e;

  // op_a_sel: 0 = rs1, 1 = PC.  op_b_sel: 0 = rs2, 1 = immediate.
  typedef struct packed {
    logic               rd_wren;
    logic               mem_wren;
    logic               mem_rden;
    logic               op_a_sel;
    logic               op_b_sel;
    logic [1:0]         wb_sel;
    logic [ALU_OPW-1:0] alu_op;
    logic [2:0]         funct3;
    logic [1:0]         lsu_size;
    logic               l_unsigned;
    logic               is_branch;
    logic               br_un;
    logic               is_jump;
    logic               is_muldiv;
    logic               insn_vld;
  } ex_ctrl_t;

  typedef struct packed {
    ex_ctrl_t ctrl;
    logic     use_rs1;
    logic     use_rs2;
  } dec_t;

  // Base integer op from funct3; alt selects SUB/SRA (funct7[5]).
  function automatic alu_op_e base_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic dec_t decode(input logic [6:0] f7, input logic [2:0] f3,
                                  input logic [6:0] op, input logic en_m);
    dec_t d;
    logic illegal;
    d             = '0;
    illegal       = 1'b0;
    d.ctrl.funct3 = f3;
    d.use_rs1     = 1'b1;
    case (op)
      OP_RTYPE: begin
        d.use_rs2      = 1'b1;
        d.ctrl.rd_wren = 1'b1;
        if (f7 == 7'b0000000) d.ctrl.alu_op = base_alu(f3, 1'b0);
        else if (f7 == 7'b0100000) begin
          illegal       = !(f3 == 3'b000 || f3 == 3'b101);
          d.ctrl.alu_op = base_alu(f3, 1'b1);
        end else if (f7 == 7'b0000001 && en_m) begin
          d.ctrl.is_muldiv = 1'b1;
          d.ctrl.alu_op    = ALU_MUL + {2'b00, f3};
        end else illegal = 1'b1;
      end
      OP_ITYPE: begin
        d.ctrl.rd_wren  = 1'b1;
        d.ctrl.op_b_sel = 1'b1;
        d.ctrl.alu_op   = base_alu(f3, f3 == 3'b101 && f7[5]);
        // Only shifts carry funct7 constraints; other I-types use those bits as immediate.
        if (f3 == 3'b001) illegal = (f7 != 7'b0000000);
        if (f3 == 3'b101) illegal = !(f7 == 7'b0000000 || f7 == 7'b0100000);
      end
      OP_LOAD: begin
        d.ctrl.rd_wren    = 1'b1;
        d.ctrl.mem_rden   = 1'b1;
        d.ctrl.op_b_sel   = 1'b1;
        d.ctrl.wb_sel     = WB_MEM;
        d.ctrl.lsu_size   = f3[1:0];
        d.ctrl.l_unsigned = f3[2];
        illegal = (f3[1:0] == 2'b11) || (f3[2] && f3[1]);
      end
      OP_STORE: begin
        d.use_rs2       = 1'b1;
        d.ctrl.mem_wren = 1'b1;
        d.ctrl.op_b_sel = 1'b1;
        d.ctrl.lsu_size = f3[1:0];
        illegal = f3[2] || (f3[1:0] == 2'b11);
      end
      OP_BRANCH: begin
        // ALU does the compare; the target adder lives in EX.
        d.use_rs2        = 1'b1;
        d.ctrl.is_branch = 1'b1;
        d.ctrl.br_un     = f3[1];
        d.ctrl.alu_op    = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        illegal = (f3[2:1] == 2'b01);
      end
      OP_JAL: begin
        d.use_rs1       = 1'b0;
        d.ctrl.rd_wren  = 1'b1;
        d.ctrl.is_jump  = 1'b1;
        d.ctrl.op_a_sel = 1'b1;
        d.ctrl.op_b_sel = 1'b1;
        d.ctrl.wb_sel   = WB_PC4;
      end
      OP_JALR: begin
        d.ctrl.rd_wren  = 1'b1;
        d.ctrl.is_jump  = 1'b1;
        d.ctrl.op_b_sel = 1'b1;
        d.ctrl.wb_sel   = WB_PC4;
        illegal = (f3 != 3'b000);
      end
      OP_LUI: begin
        d.use_rs1       = 1'b0;
        d.ctrl.rd_wren  = 1'b1;
        d.ctrl.op_b_sel = 1'b1;
        d.ctrl.wb_sel   = WB_IMM;
      end
      OP_AUIPC: begin
        d.use_rs1       = 1'b0;
        d.ctrl.rd_wren  = 1'b1;
        d.ctrl.op_a_sel = 1'b1;
        d.ctrl.op_b_sel = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    // Illegal ops still flow down the pipe for trapping, but must have no side effects.
    if (illegal) begin
      d.ctrl.rd_wren   = 1'b0;
      d.ctrl.mem_wren  = 1'b0;
      d.ctrl.mem_rden  = 1'b0;
      d.ctrl.is_branch = 1'b0;
      d.ctrl.is_jump   = 1'b0;
      d.ctrl.is_muldiv = 1'b0;
    end
    d.ctrl.insn_vld = !illegal;
    return d;
  endfunction

endpackage

// File: rtl/decode_issue_stage_scoreboard.sv
// scoreboard_cnt: per-register countdown of EX-advance cycles until a result is forwardable.
//   i_adv        : pipeline advances this cycle (counters decrement / update)
//   i_set        : an instruction is captured into ID/EX this cycle
//   i_wr_en/i_rd : destination of the captured instruction
//   i_is_load / i_is_muldiv : select the latency to load for i_rd
//   i_rs1/i_rs2/i_use_* : sources of the ID instruction; o_hazard if any is still pending
module scoreboard_cnt
  import decode_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_adv,
  input  logic       i_set,
  input  logic       i_wr_en,
  input  logic       i_is_load,
  input  logic       i_is_muldiv,
  input  logic [4:0] i_rd,
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  input  logic       i_use_rs1,
  input  logic       i_use_rs2,
  output logic       o_hazard
);
  localparam int MAX_LAT = (LOAD_LAT > MD_LAT) ? LOAD_LAT : MD_LAT;
  localparam int CW      = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

  logic [CW-1:0] cnt_q [32];
  logic [CW-1:0] cnt_d [32];

  // Hazard uses pre-update counts, so lw x5,0(x5) checks x5 against older producers only.
  assign o_hazard = (i_use_rs1 && i_rs1 != 5'd0 && cnt_q[i_rs1] != '0) ||
                    (i_use_rs2 && i_rs2 != 5'd0 && cnt_q[i_rs2] != '0);

  always_comb begin
    for (int i = 0; i < 32; i++) cnt_d[i] = cnt_q[i];
    if (i_adv) begin
      for (int i = 1; i < 32; i++)
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CW'(1);
      // A fresh writer overrides the decrement; single-cycle producers clear the entry.
      if (i_set && i_wr_en && i_rd != 5'd0)
        cnt_d[i_rd] = i_is_load   ? CW'(LOAD_LAT) :
                      i_is_muldiv ? CW'(MD_LAT)   : '0;
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: RV32I(+M) decode in ID, scoreboard hazard check, ID/EX register.
//   i_id_instr/i_id_vld : instruction from IF/ID;  o_id_rdy : accepted this cycle
//   i_ex_stall          : freeze ID/EX (and the scoreboard)
//   i_flush             : drop the ID instruction (redirect from EX)
//   o_ex_*              : registered control bundle, register indices, source usage, raw instr
module decode_issue_stage
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int EN_M     = 0,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 3,
  parameter int ALU_OPW  = 5
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [XLEN-1:0] i_id_instr,
  input  logic            i_id_vld,
  output logic            o_id_rdy,
  input  logic            i_ex_stall,
  input  logic            i_flush,
  output logic            o_ex_vld,
  output ex_ctrl_t        o_ex_ctrl,
  output logic [4:0]      o_ex_rd,
  output logic [4:0]      o_ex_rs1,
  output logic [4:0]      o_ex_rs2,
  output logic            o_ex_use_rs1,
  output logic            o_ex_use_rs2,
  output logic [XLEN-1:0] o_ex_instr
);
  // The control struct width is fixed by the package; catch a mismatched override early.
  if (ALU_OPW != decode_pkg::ALU_OPW) begin : g_opw_chk
    $error("ALU_OPW must equal decode_pkg::ALU_OPW");
  end

  dec_t       dec;
  logic       hazard;
  logic       capture;
  logic [4:0] id_rd, id_rs1, id_rs2;

  logic            ex_vld_q, ex_vld_d;
  ex_ctrl_t        ex_ctrl_q, ex_ctrl_d;
  logic [4:0]      ex_rd_q, ex_rd_d, ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic            ex_use_rs1_q, ex_use_rs1_d, ex_use_rs2_q, ex_use_rs2_d;
  logic [XLEN-1:0] ex_instr_q, ex_instr_d;

  assign dec    = decode(i_id_instr[31:25], i_id_instr[14:12], i_id_instr[6:0], EN_M != 0);
  assign id_rd  = i_id_instr[11:7];
  assign id_rs1 = i_id_instr[19:15];
  assign id_rs2 = i_id_instr[24:20];

  assign o_id_rdy = !i_ex_stall && !hazard;
  assign capture  = i_id_vld && o_id_rdy && !i_flush;

  scoreboard_cnt #(.LOAD_LAT(LOAD_LAT), .MD_LAT(MD_LAT)) u_sb (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_adv       (!i_ex_stall),
    .i_set       (capture),
    .i_wr_en     (dec.ctrl.rd_wren),
    .i_is_load   (dec.ctrl.mem_rden),
    .i_is_muldiv (dec.ctrl.is_muldiv),
    .i_rd        (id_rd),
    .i_rs1       (id_rs1),
    .i_rs2       (id_rs2),
    .i_use_rs1   (dec.use_rs1),
    .i_use_rs2   (dec.use_rs2),
    .o_hazard    (hazard)
  );

  always_comb begin
    ex_vld_d     = ex_vld_q;
    ex_ctrl_d    = ex_ctrl_q;
    ex_rd_d      = ex_rd_q;
    ex_rs1_d     = ex_rs1_q;
    ex_rs2_d     = ex_rs2_q;
    ex_use_rs1_d = ex_use_rs1_q;
    ex_use_rs2_d = ex_use_rs2_q;
    ex_instr_d   = ex_instr_q;
    if (!i_ex_stall) begin
      if (capture) begin
        ex_vld_d     = 1'b1;
        ex_ctrl_d    = dec.ctrl;
        ex_rd_d      = id_rd;
        ex_rs1_d     = id_rs1;
        ex_rs2_d     = id_rs2;
        ex_use_rs1_d = dec.use_rs1;
        ex_use_rs2_d = dec.use_rs2;
        ex_instr_d   = i_id_instr;
      end else begin
        // Bubble looks exactly like the reset state so EX sees a clean NOP.
        ex_vld_d     = 1'b0;
        ex_ctrl_d    = '0;
        ex_rd_d      = '0;
        ex_rs1_d     = '0;
        ex_rs2_d     = '0;
        ex_use_rs1_d = 1'b0;
        ex_use_rs2_d = 1'b0;
        ex_instr_d   = NOP;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ex_vld_q     <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_rd_q      <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_use_rs1_q <= 1'b0;
      ex_use_rs2_q <= 1'b0;
      ex_instr_q   <= NOP;
    end else begin
      ex_vld_q     <= ex_vld_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_rd_q      <= ex_rd_d;
      ex_rs1_q     <= ex_rs1_d;
      ex_rs2_q     <= ex_rs2_d;
      ex_use_rs1_q <= ex_use_rs1_d;
      ex_use_rs2_q <= ex_use_rs2_d;
      ex_instr_q   <= ex_instr_d;
    end
  end

  assign o_ex_vld     = ex_vld_q;
  assign o_ex_ctrl    = ex_ctrl_q;
  assign o_ex_rd      = ex_rd_q;
  assign o_ex_rs1     = ex_rs1_q;
  assign o_ex_rs2     = ex_rs2_q;
  assign o_ex_use_rs1 = ex_use_rs1_q;
  assign o_ex_use_rs2 = ex_use_rs2_q;
  assign o_ex_instr   = ex_instr_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed table-driven bench for decode_issue_stage. Main instance: EN_M=1, LOAD_LAT=1,
// MD_LAT=3. Second instance (EN_M=0) shares the inputs for the illegal-M checks.
module tb_decode_issue_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instr;
  logic        id_vld, ex_stall, flush;

  logic        rdy, ex_vld, u1, u2;
  ex_ctrl_t    ctrl;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] ex_instr;

  logic        rdy0, ex_vld0, u10, u20;
  ex_ctrl_t    ctrl0;
  logic [4:0]  rd0, rs10, rs20;
  logic [31:0] ex_instr0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_issue_stage #(.EN_M(1), .LOAD_LAT(1), .MD_LAT(3)) dut (
    .i_clk(clk), .i_reset(rst), .i_id_instr(id_instr), .i_id_vld(id_vld), .o_id_rdy(rdy),
    .i_ex_stall(ex_stall), .i_flush(flush), .o_ex_vld(ex_vld), .o_ex_ctrl(ctrl),
    .o_ex_rd(rd), .o_ex_rs1(rs1), .o_ex_rs2(rs2), .o_ex_use_rs1(u1), .o_ex_use_rs2(u2),
    .o_ex_instr(ex_instr));

  decode_issue_stage #(.EN_M(0), .LOAD_LAT(1), .MD_LAT(3)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_id_instr(id_instr), .i_id_vld(id_vld), .o_id_rdy(rdy0),
    .i_ex_stall(ex_stall), .i_flush(flush), .o_ex_vld(ex_vld0), .o_ex_ctrl(ctrl0),
    .o_ex_rd(rd0), .o_ex_rs1(rs10), .o_ex_rs2(rs20), .o_ex_use_rs1(u10), .o_ex_use_rs2(u20),
    .o_ex_instr(ex_instr0));

  // flags = {rd_wren, mem_wren, mem_rden, is_branch, is_jump, is_muldiv, insn_vld}
  typedef struct {
    logic [31:0] instr;
    logic        vld, stall, flsh;
    logic        rdy, ev;
    logic [4:0]  rd, alu;
    logic [6:0]  fl;
    logic [1:0]  use_;
  } vec_t;

  localparam logic [6:0] F_ALU = 7'b1000001, F_LD = 7'b1010001, F_MD = 7'b1000011;
  localparam logic [6:0] F_ST = 7'b0100001, F_BR = 7'b0001001, F_JMP = 7'b1000101;

  localparam logic [31:0] ADD3  = 32'h002081B3, LW5 = 32'h0000A283, ADD6 = 32'h00028333;
  localparam logic [31:0] LW0   = 32'h0000A003, ADDX0 = 32'h00000333;
  localparam logic [31:0] MUL7  = 32'h022083B3, SUB8 = 32'h40138433;
  localparam logic [31:0] LW9   = 32'h0000A483, ADD10 = 32'h00048533;
  localparam logic [31:0] SW    = 32'h0020A223, BEQ = 32'h00208463;
  localparam logic [31:0] LUI11 = 32'h123455B7, JAL1 = 32'h000000EF, BAD = 32'hFFFFFFFF;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [31:0] ins, input logic v, s, f, r, ev,
                              input logic [4:0] d, a, input logic [6:0] fl,
                              input logic [1:0] u);
    vec_t t;
    t.instr = ins; t.vld = v; t.stall = s; t.flsh = f; t.rdy = r; t.ev = ev;
    t.rd = d; t.alu = a; t.fl = fl; t.use_ = u;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, s, f);
    @(negedge clk);
    id_instr = ins; id_vld = v; ex_stall = s; flush = f;
    #1;
  endtask

  function automatic logic [6:0] flags(input ex_ctrl_t c);
    return {c.rd_wren, c.mem_wren, c.mem_rden, c.is_branch, c.is_jump, c.is_muldiv,
            c.insn_vld};
  endfunction

  task automatic run_vec(input vec_t t, input int idx);
    drive(t.instr, t.vld, t.stall, t.flsh);
    chk($sformatf("v%0d.rdy", idx), 32'(rdy), 32'(t.rdy));
    @(posedge clk); #1;
    chk($sformatf("v%0d.ex_vld", idx), 32'(ex_vld), 32'(t.ev));
    chk($sformatf("v%0d.rd", idx), 32'(rd), 32'(t.rd));
    chk($sformatf("v%0d.alu_op", idx), 32'(ctrl.alu_op), 32'(t.alu));
    chk($sformatf("v%0d.flags", idx), 32'(flags(ctrl)), 32'(t.fl));
    chk($sformatf("v%0d.use", idx), 32'({u1, u2}), 32'(t.use_));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".ex_vld"}, 32'(ex_vld), 32'd0);
    chk({tag, ".ctrl"}, 32'(ctrl), 32'd0);
    chk({tag, ".idx"}, 32'({rd, rs1, rs2, u1, u2}), 32'd0);
    chk({tag, ".instr"}, ex_instr, 32'h0000_0013);
  endtask

  initial begin
    rst = 1'b1; id_instr = '0; id_vld = 1'b0; ex_stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_state("reset");
    @(negedge clk) rst = 1'b0;

    //            instr  vld s f  rdy ev rd  alu  flags  use
    tbl.push_back(mk(ADD3,  1, 0, 0, 1, 1, 3,  0,  F_ALU, 2'b11));
    tbl.push_back(mk(LW5,   1, 0, 0, 1, 1, 5,  0,  F_LD,  2'b10));
    tbl.push_back(mk(ADD6,  1, 0, 0, 0, 0, 0,  0,  7'd0,  2'b00)); // load-use bubble
    tbl.push_back(mk(ADD6,  1, 0, 0, 1, 1, 6,  0,  F_ALU, 2'b11));
    tbl.push_back(mk(LW0,   1, 0, 0, 1, 1, 0,  0,  F_LD,  2'b10));
    tbl.push_back(mk(ADDX0, 1, 0, 0, 1, 1, 6,  0,  F_ALU, 2'b11)); // x0 never pends
    tbl.push_back(mk(MUL7,  1, 0, 0, 1, 1, 7,  16, F_MD,  2'b11));
    tbl.push_back(mk(SUB8,  1, 0, 0, 0, 0, 0,  0,  7'd0,  2'b00));
    tbl.push_back(mk(SUB8,  1, 0, 0, 0, 0, 0,  0,  7'd0,  2'b00));
    tbl.push_back(mk(SUB8,  1, 0, 0, 0, 0, 0,  0,  7'd0,  2'b00));
    tbl.push_back(mk(SUB8,  1, 0, 0, 1, 1, 8,  1,  F_ALU, 2'b11));
    tbl.push_back(mk(LW9,   1, 0, 1, 1, 0, 0,  0,  7'd0,  2'b00)); // flushed
    tbl.push_back(mk(ADD10, 1, 0, 0, 1, 1, 10, 0,  F_ALU, 2'b11));
    tbl.push_back(mk(32'd0, 0, 0, 0, 1, 0, 0,  0,  7'd0,  2'b00)); // idle
    tbl.push_back(mk(SW,    1, 0, 0, 1, 1, 4,  0,  F_ST,  2'b11));
    tbl.push_back(mk(BEQ,   1, 0, 0, 1, 1, 8,  1,  F_BR,  2'b11));
    tbl.push_back(mk(LUI11, 1, 0, 0, 1, 1, 11, 0,  F_ALU, 2'b00));
    tbl.push_back(mk(JAL1,  1, 0, 0, 1, 1, 1,  0,  F_JMP, 2'b00));
    tbl.push_back(mk(BAD,   1, 0, 0, 1, 1, 31, 0,  7'd0,  2'b10)); // illegal still issues
    tbl.push_back(mk(LW5,   1, 0, 0, 1, 1, 5,  0,  F_LD,  2'b10));
    tbl.push_back(mk(ADD6,  1, 1, 0, 0, 1, 5,  0,  F_LD,  2'b10)); // stall holds
    tbl.push_back(mk(ADD6,  1, 1, 0, 0, 1, 5,  0,  F_LD,  2'b10));
    tbl.push_back(mk(ADD6,  1, 0, 0, 0, 0, 0,  0,  7'd0,  2'b00)); // one bubble left
    tbl.push_back(mk(ADD6,  1, 0, 0, 1, 1, 6,  0,  F_ALU, 2'b11));
    tbl.push_back(mk(LW9,   1, 1, 1, 0, 1, 6,  0,  F_ALU, 2'b11)); // stall+flush: hold
    tbl.push_back(mk(ADD10, 1, 0, 0, 1, 1, 10, 0,  F_ALU, 2'b11)); // x9 never pended

    foreach (tbl[i]) run_vec(tbl[i], i);

    // EN_M=0: mul is illegal, has no side effects, and leaves no scoreboard entry.
    @(negedge clk) rst = 1'b1;
    #2 rst = 1'b0;
    drive(MUL7, 1'b1, 1'b0, 1'b0);
    chk("m0.mul.rdy", 32'(rdy0), 32'd1);
    @(posedge clk); #1;
    chk("m0.mul.ex_vld", 32'(ex_vld0), 32'd1);
    chk("m0.mul.flags", 32'(flags(ctrl0)), 32'd0);
    drive(SUB8, 1'b1, 1'b0, 1'b0);
    chk("m0.sub.rdy", 32'(rdy0), 32'd1);
    chk("m1.sub.rdy", 32'(rdy), 32'd0);
    @(posedge clk); #1;
    chk("m0.sub.rd", 32'({ex_vld0, rd0}), 32'({1'b1, 5'd8}));

    // Reset while a load is pending: nothing survives.
    drive(LW5, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("rm.lw.rd", 32'({ex_vld, rd}), 32'({1'b1, 5'd5}));
    @(negedge clk);
    id_vld = 1'b0; rst = 1'b1;
    #1 check_reset_state("rm");
    #1 rst = 1'b0;
    drive(ADD6, 1'b1, 1'b0, 1'b0);
    chk("rm.add6.rdy", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    chk("rm.add6.rd", 32'({ex_vld, rd}), 32'({1'b1, 5'd6}));
    drive(SUB8, 1'b1, 1'b0, 1'b0);
    chk("rm.sub8.rdy", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    drive(32'd0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
